// File: rtl/program_loader.sv
// program_loader: loads instruction memory from a host byte stream, then releases the CPU.
// Frame format: SYNC_BYTE, word count N (1..MEM_DEPTH), then N 32-bit little-endian words.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   byte_data/valid     incoming stream byte; byte_ready is the registered accept signal
//   reload              synchronous abort/restart pulse, overrides every transition
//   imem_we/addr/wdata  instruction memory write port, one strobe per assembled word
//   cpu_run, done       image fully loaded, processor may execute
//   error               illegal word count received
module program_loader #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH),
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic                 reload,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [WORD_SIZE-1:0] imem_wdata,
  output logic                 cpu_run,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BYTE_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]     last_idx_q, last_idx_d;
  logic [WORD_SIZE-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]     imem_addr_q, imem_addr_d;
  logic [WORD_SIZE-1:0]  imem_wdata_q, imem_wdata_d;
  logic                  imem_we_q, imem_we_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  done_q, done_d;
  logic                  cpu_run_q, cpu_run_d;
  logic                  error_q, error_d;
  logic                  accept_c;

  assign accept_c = byte_valid && byte_ready_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    last_idx_d   = last_idx_q;
    word_d       = word_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (reload) begin
      state_d    = ST_IDLE;
      byte_idx_d = '0;
      word_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c && (byte_data == SYNC_BYTE)) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (accept_c) begin
            if ((byte_data == 8'd0) || (32'(byte_data) > MEM_DEPTH)) begin
              state_d = ST_ERR;
            end else begin
              // Store N-1 so the final-word test is a plain equality on the index
              last_idx_d = ADDR_W'(32'(byte_data) - 32'd1);
              word_idx_d = '0;
              byte_idx_d = '0;
              state_d    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            // Shift right so the first byte of the word ends up in the low lane
            word_d     = {byte_data, word_q[WORD_SIZE-1:BYTE_W]};
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            if (byte_idx_q == BYTE_IDX_W'(3)) begin
              imem_addr_d  = word_idx_q;
              imem_wdata_d = word_d;
              state_d      = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = (word_idx_q == last_idx_q) ? ST_DONE : ST_DATA;
        end
        default: state_d = state_q;
      endcase
    end

    imem_we_d    = (state_d == ST_WRITE);
    byte_ready_d = (state_d == ST_IDLE) || (state_d == ST_COUNT) || (state_d == ST_DATA);
    done_d       = (state_d == ST_DONE);
    cpu_run_d    = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      last_idx_q   <= '0;
      word_q       <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_we_q    <= 1'b0;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      cpu_run_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      last_idx_q   <= last_idx_d;
      word_q       <= word_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_we_q    <= imem_we_d;
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
      cpu_run_q    <= cpu_run_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign cpu_run    = cpu_run_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frame stimulus for program_loader, checked against
// expected write lists built from the frame contents.
module tb_program_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  typedef logic [7:0] byte_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  logic          clk;
  logic          rst;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          done;
  logic          error;

  int  chk_cnt  = 0;
  int  pass_cnt = 0;
  int  cyc      = 0;
  int  long_pulse = 0;
  bit  we_prev  = 0;
  wr_t wr_q[$];

  program_loader #(.WORD_SIZE(32), .MEM_DEPTH(DEPTH), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .done(done), .error(error)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Write-port monitor: records every strobe and flags strobes longer than one cycle
  always @(negedge clk) begin
    if (rst && imem_we) begin
      wr_q.push_back('{imem_addr, imem_wdata, cyc});
      if (we_prev) long_pulse++;
    end
    we_prev = rst && imem_we;
  end

  function automatic logic [31:0] le_word(input byte_t b0, input byte_t b1, input byte_t b2, input byte_t b3);
    return 32'(b0) + 32'(b1) * 32'd256 + 32'(b2) * 32'd65536 + 32'(b3) * 32'd16777216;
  endfunction

  task automatic send_byte(input byte_t b, input bit gaps);
    bit rdy;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_data  = b;
    byte_valid = 1;
    n = 0;
    do begin
      rdy = byte_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 100);
    byte_valid = 0;
    if (!rdy) begin
      chk_cnt++;
      $display("FAIL send_byte timeout: byte %h never accepted (byte_ready=%b, required 1)", b, byte_ready);
    end
  endtask

  task automatic send_frame(input byte_t fr[$], input bit gaps);
    foreach (fr[i]) send_byte(fr[i], gaps);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 0; reload = 0; byte_valid = 0; byte_data = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    wr_q.delete();
    long_pulse = 0;
  endtask

  task automatic pulse_reload();
    reload = 1;
    @(negedge clk);
    reload = 0;
    @(negedge clk);
    wr_q.delete();
    long_pulse = 0;
  endtask

  task automatic test_reset();
    byte_t fr[$];
    rst = 0; reload = 0; byte_valid = 0; byte_data = 0;
    @(negedge clk);
    chk_cnt++;
    if ({byte_ready, imem_we, done, error, cpu_run} !== 5'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      $display("FAIL reset_outputs: ready/we/done/err/run=%b addr=%h wdata=%h, required all 0",
               {byte_ready, imem_we, done, error, cpu_run}, imem_addr, imem_wdata);
    end else pass_cnt++;
    rst = 1;
    @(negedge clk);
    chk_cnt++;
    if (byte_ready !== 1'b1) $display("FAIL reset_ready_release: byte_ready=%b, required 1", byte_ready);
    else pass_cnt++;

    // Asynchronous reset in the middle of a word
    fr = '{8'hA5, 8'h04, 8'h11, 8'h22};
    send_frame(fr, 0);
    byte_data = 8'h33; byte_valid = 1;
    #2 rst = 0;
    #1;
    chk_cnt++;
    if ({byte_ready, imem_we, done, error, cpu_run} !== 5'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      $display("FAIL reset_mid_data: ready/we/done/err/run=%b addr=%h wdata=%h, required all 0",
               {byte_ready, imem_we, done, error, cpu_run}, imem_addr, imem_wdata);
    end else pass_cnt++;
    byte_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_cnt++;
    if (byte_ready !== 1'b1 || wr_q.size() != 0) $display("FAIL reset_mid_data_release: ready=%b writes=%0d, required 1 and 0", byte_ready, wr_q.size());
    else pass_cnt++;

    // Asynchronous reset while the write strobe is high
    fr = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr, 0);
    chk_cnt++;
    if (imem_we !== 1'b1) $display("FAIL write_before_reset: imem_we=%b, required 1", imem_we);
    else pass_cnt++;
    #1 rst = 0;
    #1;
    chk_cnt++;
    if (imem_we !== 1'b0) $display("FAIL reset_during_write: imem_we=%b, required 0", imem_we);
    else pass_cnt++;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    wr_q.delete();
  endtask

  task automatic test_single_word();
    byte_t fr[$];
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(fr, 1);
    chk_cnt++;
    if (imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'h12345678)
      $display("FAIL single_write: we=%b addr=%h wdata=%h, required 1 0 12345678", imem_we, imem_addr, imem_wdata);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b1 || cpu_run !== 1'b1 || imem_we !== 1'b0 || error !== 1'b0)
      $display("FAIL single_done: done=%b run=%b we=%b err=%b, required 1 1 0 0", done, cpu_run, imem_we, error);
    else pass_cnt++;
    // Bytes offered in DONE must be refused
    byte_data = 8'hA5; byte_valid = 1;
    repeat (4) @(negedge clk);
    byte_valid = 0;
    chk_cnt++;
    if (byte_ready !== 1'b0 || wr_q.size() != 1 || done !== 1'b1)
      $display("FAIL done_refuses_bytes: ready=%b writes=%0d done=%b, required 0 1 1", byte_ready, wr_q.size(), done);
    else pass_cnt++;
  endtask

  task automatic run_image(input int n, input bit gaps, input string tag);
    byte_t fr[$];
    logic [31:0] exp[$];
    byte_t b[4];
    bit ok;
    int bad;
    fr = '{8'hA5, 8'(n)};
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b[k] = 8'($urandom);
        fr.push_back(b[k]);
      end
      exp.push_back(le_word(b[0], b[1], b[2], b[3]));
    end
    send_frame(fr, gaps);
    wait_done(ok);
    chk_cnt++;
    if (!ok || cpu_run !== 1'b1) $display("FAIL %s_done: done=%b cpu_run=%b, required 1 1", tag, done, cpu_run);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (wr_q.size() != n || long_pulse != 0)
      $display("FAIL %s_write_count: writes=%0d long_pulses=%0d, required %0d and 0", tag, wr_q.size(), long_pulse, n);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      if (wr_q[i].addr !== AW'(i) || wr_q[i].data !== exp[i]) begin
        bad++;
        $display("FAIL %s_write[%0d]: addr=%h data=%h, required %h %h", tag, i, wr_q[i].addr, wr_q[i].data, AW'(i), exp[i]);
      end
      if (!gaps && i > 0 && (wr_q[i].cyc - wr_q[i-1].cyc) != 5) begin
        bad++;
        $display("FAIL %s_spacing[%0d]: %0d cycles between writes, required 5", tag, i, wr_q[i].cyc - wr_q[i-1].cyc);
      end
    end
    chk_cnt++;
    if (bad == 0) pass_cnt++;
    chk_cnt++;
    if (imem_addr !== AW'(n - 1) || imem_wdata !== exp[n-1] || imem_we !== 1'b0)
      $display("FAIL %s_hold: addr=%h wdata=%h we=%b, required %h %h 0", tag, imem_addr, imem_wdata, imem_we, AW'(n - 1), exp[n-1]);
    else pass_cnt++;
  endtask

  task automatic test_full_image();
    do_reset();
    run_image(DEPTH, 1, "full");
  endtask

  task automatic test_back_to_back();
    pulse_reload();
    run_image(4, 0, "b2b");
  endtask

  task automatic test_bad_count();
    byte_t fr[$];
    byte_t counts[3];
    counts[0] = 8'h00;
    counts[1] = 8'h21;
    counts[2] = 8'($urandom_range(34, 255));
    for (int i = 0; i < 3; i++) begin
      pulse_reload();
      chk_cnt++;
      if (error !== 1'b0 || byte_ready !== 1'b1 || done !== 1'b0)
        $display("FAIL bad_count_reload[%0d]: err=%b ready=%b done=%b, required 0 1 0", i, error, byte_ready, done);
      else pass_cnt++;
      fr = '{8'hA5, counts[i]};
      send_frame(fr, 1);
      @(negedge clk);
      byte_data = 8'h5A; byte_valid = 1;
      repeat (3) @(negedge clk);
      byte_valid = 0;
      chk_cnt++;
      if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_run !== 1'b0 || done !== 1'b0 || wr_q.size() != 0)
        $display("FAIL bad_count[%h]: err=%b ready=%b run=%b done=%b writes=%0d, required 1 0 0 0 0",
                 counts[i], error, byte_ready, cpu_run, done, wr_q.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_garbage_then_sync();
    byte_t fr[$];
    bit ok;
    pulse_reload();
    fr = '{8'h00, 8'hFF};
    repeat (3) begin
      byte_t g;
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      fr.push_back(g);
    end
    fr.push_back(8'hA5); fr.push_back(8'h01);
    fr.push_back(8'hEF); fr.push_back(8'hBE); fr.push_back(8'hAD); fr.push_back(8'hDE);
    send_frame(fr, 1);
    wait_done(ok);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (!ok || wr_q.size() != 1) $display("FAIL garbage_writes: done=%b writes=%0d, required 1 1", done, wr_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (wr_q.size() < 1 || wr_q[0].addr !== 5'd0 || wr_q[0].data !== 32'hDEADBEEF)
      $display("FAIL garbage_data: addr=%h data=%h, required 0 deadbeef", imem_addr, imem_wdata);
    else pass_cnt++;
  endtask

  task automatic test_reload();
    byte_t fr[$];
    byte_t b[4];
    bit ok;
    pulse_reload();
    fr = '{8'hA5, 8'h02, 8'h11, 8'h22};
    send_frame(fr, 1);
    pulse_reload();
    chk_cnt++;
    if (byte_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || imem_we !== 1'b0)
      $display("FAIL reload_abort: ready=%b done=%b err=%b we=%b, required 1 0 0 0", byte_ready, done, error, imem_we);
    else pass_cnt++;
    // A sync byte offered together with reload must be dropped
    reload = 1; byte_data = 8'hA5; byte_valid = 1;
    @(negedge clk);
    reload = 0; byte_valid = 0;
    fr = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
    send_frame(fr, 0);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_q.size() != 0 || done !== 1'b0 || byte_ready !== 1'b1)
      $display("FAIL reload_same_cycle_byte: writes=%0d done=%b ready=%b, required 0 0 1", wr_q.size(), done, byte_ready);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    fr = '{8'hA5, 8'h01, b[0], b[1], b[2], b[3]};
    send_frame(fr, 1);
    wait_done(ok);
    chk_cnt++;
    if (!ok || wr_q.size() != 1 || wr_q[0].addr !== 5'd0 || wr_q[0].data !== le_word(b[0], b[1], b[2], b[3]))
      $display("FAIL reload_new_frame: done=%b writes=%0d wdata=%h, required 1 1 %h",
               done, wr_q.size(), imem_wdata, le_word(b[0], b[1], b[2], b[3]));
    else pass_cnt++;
  endtask

  initial begin
    rst = 0; reload = 0; byte_valid = 0; byte_data = 0;
    test_reset();
    test_single_word();
    test_full_image();
    test_back_to_back();
    test_bad_count();
    test_garbage_then_sync();
    test_reload();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
